// File: rtl/sram_access_arbiter_pkg.sv
// Shared types and defaults for the SRAM access arbiter: sequencer states,
// grant encoding and the wait-counter sizing helper.
package sram_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_FINISH
  } state_e;

  typedef enum logic {
    GNT_IF,
    GNT_MEM
  } gnt_e;

  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// CPU-side request/response signals and SRAM pin bundle of the arbiter.
interface sram_access_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic [DATA_W-1:0] ifData;
  logic              ifReady;
  logic              memReadReq;
  logic              memWriteReq;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWriteData;
  logic [DATA_W-1:0] memReadData;
  logic              memReady;
  logic              stallOut;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramDataOut;
  logic              ramDataOE;
  logic [DATA_W-1:0] ramDataIn;
  logic              ramCE_n;
  logic              ramOE_n;
  logic              ramWE_n;

  modport slave (
    input  ifReq, ifAddr, memReadReq, memWriteReq, memAddr, memWriteData, ramDataIn,
    output ifData, ifReady, memReadData, memReady, stallOut,
           ramAddr, ramDataOut, ramDataOE, ramCE_n, ramOE_n, ramWE_n
  );

  modport master (
    output ifReq, ifAddr, memReadReq, memWriteReq, memAddr, memWriteData, ramDataIn,
    input  ifData, ifReady, memReadData, memReady, stallOut,
           ramAddr, ramDataOut, ramDataOE, ramCE_n, ramOE_n, ramWE_n
  );
endinterface

// File: rtl/sram_phy_seq.sv
// SRAM access sequencer: SETUP / ACCESS (wait states) / FINISH timing with
// registered strobes. A new start is accepted in IDLE or directly from FINISH.
module sram_phy_seq
  import sram_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output state_e            state,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_data_oe,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);
  localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;
  logic             wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      wr          <= 1'b0;
      rdata       <= '0;
      done        <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_data_oe <= 1'b0;
      ram_ce_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        // FINISH shares IDLE's launch path so a queued requester starts without a bubble
        ST_IDLE, ST_FINISH: begin
          if (start) begin
            state       <= ST_SETUP;
            ram_addr    <= addr;
            ram_wdata   <= wdata;
            wr          <= write;
            ram_ce_n    <= 1'b0;
            ram_data_oe <= write;
          end else begin
            state       <= ST_IDLE;
            ram_ce_n    <= 1'b1;
            ram_data_oe <= 1'b0;
          end
        end
        ST_SETUP: begin
          state    <= ST_ACCESS;
          wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
          if (wr) ram_we_n <= 1'b0;
          else    ram_oe_n <= 1'b0;
        end
        ST_ACCESS: begin
          if (wait_cnt == '0) begin
            state    <= ST_FINISH;
            ram_oe_n <= 1'b1;
            ram_we_n <= 1'b1;
            done     <= 1'b1;
            if (!wr) rdata <= ram_rdata;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one SRAM between instruction fetch and data access (MEM first) and
// stalls the pipeline until every pending request of the cycle is served.
module sram_access_arbiter
  import sram_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input logic                   CLK,
  input logic                   RST,
  sram_access_arbiter_if.slave  bus
);
  state_e            state;
  gnt_e              gnt;
  logic              gnt_wr;
  logic              phy_done;
  logic [DATA_W-1:0] phy_rdata;
  logic              start;
  logic              sel_mem;
  logic              phy_write;
  logic [ADDR_W-1:0] phy_addr;
  logic              if_done, mem_done;
  logic              if_ready, mem_ready;
  logic              mem_req, if_pend, mem_pend;
  logic              stall;
  logic [DATA_W-1:0] if_data_q, mem_rd_q;

  assign mem_req   = bus.memReadReq | bus.memWriteReq;
  assign if_pend   = bus.ifReq & ~if_done;
  assign mem_pend  = mem_req & ~mem_done;
  assign if_ready  = phy_done & (gnt == GNT_IF);
  assign mem_ready = phy_done & (gnt == GNT_MEM);
  assign stall     = RST & ((bus.ifReq & ~(if_done | if_ready)) |
                            (mem_req & ~(mem_done | mem_ready)));

  // From FINISH only the other requester may be launched
  always_comb begin
    start   = 1'b0;
    sel_mem = 1'b0;
    case (state)
      ST_IDLE: begin
        start   = if_pend | mem_pend;
        sel_mem = mem_pend;
      end
      ST_FINISH: begin
        if (gnt == GNT_IF) begin
          start   = mem_pend;
          sel_mem = 1'b1;
        end else begin
          start   = if_pend;
          sel_mem = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign phy_write = sel_mem & bus.memWriteReq;
  assign phy_addr  = sel_mem ? bus.memAddr : bus.ifAddr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gnt       <= GNT_IF;
      gnt_wr    <= 1'b0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_data_q <= '0;
      mem_rd_q  <= '0;
    end else begin
      if (start) begin
        gnt    <= sel_mem ? GNT_MEM : GNT_IF;
        gnt_wr <= phy_write;
      end
      if (if_ready)            if_data_q <= phy_rdata;
      if (mem_ready && !gnt_wr) mem_rd_q <= phy_rdata;
      // Clearing on a released stall outranks setting, so a request repeated
      // right after the pipeline advances is treated as new
      if (!stall) begin
        if_done  <= 1'b0;
        mem_done <= 1'b0;
      end else begin
        if (if_ready && bus.ifReq) if_done  <= 1'b1;
        if (mem_ready && mem_req)  mem_done <= 1'b1;
      end
    end
  end

  assign bus.ifReady     = if_ready;
  assign bus.memReady    = mem_ready;
  assign bus.stallOut    = stall;
  assign bus.ifData      = if_ready ? phy_rdata : if_data_q;
  assign bus.memReadData = (mem_ready && !gnt_wr) ? phy_rdata : mem_rd_q;

  sram_phy_seq #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_phy (
    .clk         (CLK),
    .rst_n       (RST),
    .start       (start),
    .write       (phy_write),
    .addr        (phy_addr),
    .wdata       (bus.memWriteData),
    .ram_rdata   (bus.ramDataIn),
    .state       (state),
    .rdata       (phy_rdata),
    .done        (phy_done),
    .ram_addr    (bus.ramAddr),
    .ram_wdata   (bus.ramDataOut),
    .ram_data_oe (bus.ramDataOE),
    .ram_ce_n    (bus.ramCE_n),
    .ram_oe_n    (bus.ramOE_n),
    .ram_we_n    (bus.ramWE_n)
  );
endmodule
